// File: rtl/display_mux_n.sv
// Multiplexed seven-segment driver with channel select, sequential
// binary-to-BCD conversion, leading-zero blanking and overflow dashes.
module display_mux_n #(
  parameter int NUM_DIGITS   = 4,
  parameter int NUM_CHANNELS = 4,
  parameter int VAL_W        = 16,
  parameter int REFRESH_DIV  = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CHANNELS*VAL_W-1:0] values,
  input  logic [$clog2(NUM_CHANNELS)-1:0] mode,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic                          lz_blank,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic                          frame_tick,
  output logic                          conv_busy
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = 4*NUM_DIGITS + 4;
  localparam int DW = 4*NUM_DIGITS;
  localparam int CW = $clog2(VAL_W + 1);

  function automatic longint unsigned pow10(int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAXV = pow10(NUM_DIGITS) - 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} st_t;

  st_t st, nst;

  logic [PW-1:0]    pre;
  logic [IW-1:0]    idx;
  logic             tc, last;
  logic             start_pend;
  logic             start;
  logic             ld, sh, dn;
  logic [VAL_W-1:0] sel, val, bin;
  logic [BW-1:0]    bcd, adj;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    snap;
  logic             ovf;

  assign tc    = (pre == PW'(REFRESH_DIV - 1));
  assign last  = (idx == IW'(NUM_DIGITS - 1));
  assign start = frame_tick | start_pend;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
      start_pend <= 1'b1;
    end else begin
      pre        <= tc ? '0 : pre + 1'b1;
      frame_tick <= tc && last;
      start_pend <= 1'b0;
      if (tc) idx <= last ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) st <= IDLE;
    else          st <= nst;
  end

  always_comb begin
    nst = st;
    unique case (st)
      IDLE:  if (start) nst = LOAD;
      LOAD:  nst = SHIFT;
      SHIFT: if (cnt == CW'(VAL_W - 1)) nst = DONE;
      DONE:  nst = IDLE;
      default: nst = IDLE;
    endcase
  end

  always_comb begin
    ld        = (st == LOAD);
    sh        = (st == SHIFT);
    dn        = (st == DONE);
    conv_busy = ld | sh;
  end

  // Out-of-range mode falls back to channel 0
  always_comb begin
    sel = values[VAL_W-1:0];
    for (int k = 1; k < NUM_CHANNELS; k++)
      if (int'(mode) == k) sel = values[k*VAL_W +: VAL_W];
  end

  always_comb begin
    adj = '0;
    for (int n = 0; n < BW/4; n++)
      adj[4*n +: 4] = bcd[4*n +: 4] +
        ((bcd[4*n +: 4] >= 4'd5) ? 4'd3 : 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      val  <= '0;
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
      snap <= '0;
      ovf  <= 1'b0;
    end else begin
      if (ld) begin
        val <= sel;
        bin <= sel;
        bcd <= '0;
        cnt <= '0;
      end
      if (sh) begin
        bcd <= {adj[BW-2:0], bin[VAL_W-1]};
        bin <= bin << 1;
        cnt <= cnt + 1'b1;
      end
      if (dn) begin
        snap <= bcd[DW-1:0];
        ovf  <= 64'(val) > MAXV;
      end
    end
  end

  logic [NUM_DIGITS-1:0] blank_v, an_n;
  logic [3:0]            nib;
  logic                  blk, dpm, z;
  logic [6:0]            dec, seg_n;

  // Blank a digit only when it and everything to its left is zero
  always_comb begin
    z       = 1'b1;
    blank_v = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z          = z & (snap[4*i +: 4] == 4'd0);
      blank_v[i] = z && lz_blank && (i != 0);
    end
  end

  always_comb begin
    nib  = '0;
    blk  = 1'b0;
    dpm  = 1'b0;
    an_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib     = snap[4*i +: 4];
        blk     = blank_v[i];
        dpm     = dp_mask[i];
        an_n[i] = 1'b0;
      end
    end
  end

  always_comb begin
    case (nib)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
    seg_n = ovf ? 7'b0111111 : (blk ? 7'b1111111 : dec);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an  <= ~NUM_DIGITS'(1);
      seg <= 7'b1000000;
      dp  <= 1'b1;
    end else begin
      an  <= an_n;
      seg <= seg_n;
      dp  <= ~dpm;
    end
  end

endmodule
